// File: rtl/exam_driver_if.sv
// exam_driver_if: method-call bus between the exam driver (caller) and the
// exam assignment block (callee).
//
// Handshake rule: each method has an enable (caller -> callee) and a ready
// (callee -> caller). The caller raises an enable only in a cycle where the
// matching ready is high. Every cycle with enable=1 is exactly one completed
// call. For the next method, next_k is the call argument in that cycle, and
// next is the return value, valid in that same cycle.
//
// Signals:
//   EN_start  start method enable        (master -> slave)
//   RDY_start start method ready         (slave  -> master)
//   next_k    argument of next method    (master -> slave)
//   EN_next   next method enable         (master -> slave)
//   next      return value of next       (slave  -> master)
//   RDY_next  next method ready          (slave  -> master)
interface exam_driver_if;
    logic EN_start;
    logic RDY_start;
    logic next_k;
    logic EN_next;
    logic next;
    logic RDY_next;

    modport master (
        output EN_start,
        output next_k,
        output EN_next,
        input  RDY_start,
        input  next,
        input  RDY_next
    );

    modport slave (
        input  EN_start,
        input  next_k,
        input  EN_next,
        output RDY_start,
        output next,
        output RDY_next
    );
endinterface

// File: rtl/exam_driver.sv
// exam_driver: caller-side engine for the start/next method protocol of the
// exam assignment block. One accepted go performs a start call followed by
// NCALLS next calls (argument k = pattern bit i on call i), and collects each
// returned bit into result[i].
//
// Optional feature: define EXAM_DRIVER_TIMEOUT_EN to abort a run after
// TIMEOUT consecutive cycles spent waiting on a ready (state ERR, error=1).
// Without the macro the driver waits indefinitely and error is tied to 0.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   go         launch a run (ignored while busy)
//   pattern    call arguments, latched on an accepted go
//   busy       run in progress (START or RUN)
//   done       last run ended (DONE or ERR), cleared by the next accepted go
//   error      last run aborted by timeout
//   result     bit i = value returned by next call i
//   state_dbg  current FSM state (0 IDLE, 1 START, 2 RUN, 3 DONE, 4 ERR)
//   bus        method bus towards the assignment block (master side)
module exam_driver #(
    parameter int NCALLS  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              go,
    input  logic [NCALLS-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [NCALLS-1:0] result,
    output logic [2:0]        state_dbg,
    exam_driver_if.master     bus
);

    localparam int IW = (NCALLS > 1) ? $clog2(NCALLS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCALLS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NCALLS-1:0] pat_q, pat_d;
    logic [NCALLS-1:0] res_q, res_d;
    logic              idle_like;
    logic              fire_start;
    logic              fire_next;

`ifdef EXAM_DRIVER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wait_q, wait_d;
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign error     = (state_q == S_ERR);
`else
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign error     = 1'b0;
`endif

    // Enables follow their ready combinationally; RST masks them in the reset
    // cycle so an aborted run never produces a call.
    assign fire_start   = (state_q == S_START) && bus.RDY_start && !RST;
    assign fire_next    = (state_q == S_RUN) && bus.RDY_next && !RST;
    assign bus.EN_start = fire_start;
    assign bus.EN_next  = fire_next;
    assign bus.next_k   = (state_q == S_RUN) ? pat_q[idx_q] : 1'b0;

    assign busy      = (state_q == S_START) || (state_q == S_RUN);
    assign result    = res_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        res_d   = res_q;
`ifdef EXAM_DRIVER_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        if (idle_like) begin
            if (go) begin
                state_d = S_START;
                pat_d   = pattern;
                res_d   = '0;
                idx_d   = '0;
`ifdef EXAM_DRIVER_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
        end else if ((state_q == S_START) || (state_q == S_RUN)) begin
            if (fire_start) begin
                state_d = S_RUN;
`ifdef EXAM_DRIVER_TIMEOUT_EN
                wait_d  = '0;
`endif
            end else if (fire_next) begin
                res_d[idx_q] = bus.next;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
`ifdef EXAM_DRIVER_TIMEOUT_EN
                wait_d = '0;
`endif
            end else begin
`ifdef EXAM_DRIVER_TIMEOUT_EN
                // wait_q counts the idle cycles already completed, so the
                // edge ending the TIMEOUT-th idle cycle is the abort edge.
                if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pat_q   <= '0;
            res_q   <= '0;
`ifdef EXAM_DRIVER_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            res_q   <= res_d;
`ifdef EXAM_DRIVER_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

endmodule

// File: tb/tb_exam_driver.sv
// Self-checking bench for exam_driver. The callee side answers every next
// call with the inverted argument. A run-level model predicts every output on
// every cycle; directed literal checks pin latencies and results.
module tb_exam_driver;
    localparam int NCALLS  = 8;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic [NCALLS-1:0] pattern;
    logic              busy;
    logic              done;
    logic              error;
    logic [NCALLS-1:0] result;
    logic [2:0]        state_dbg;

    exam_driver_if bus();

    // Callee: return value is the inverted argument.
    assign bus.next = ~bus.next_k;

    exam_driver #(.NCALLS(NCALLS), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (clk),
        .RST       (rst),
        .go        (go),
        .pattern   (pattern),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .result    (result),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- run-level model ----------------
    bit                chk_en   = 1'b0;
    bit                m_active = 1'b0;
    bit                m_started = 1'b0;
    bit                m_done   = 1'b0;
    bit                m_err    = 1'b0;
    logic [NCALLS-1:0] m_pat    = '0;
    logic [NCALLS-1:0] m_res    = '0;
    int                m_calls  = 0;
    int                m_idle   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_started = 0; m_done = 0; m_err = 0;
            m_res = '0; m_calls = 0; m_idle = 0;
        end else if (!m_active) begin
            if (go) begin
                m_active = 1; m_started = 0; m_done = 0; m_err = 0;
                m_pat = pattern; m_res = '0; m_calls = 0; m_idle = 0;
            end
        end else begin
            if (!m_started) begin
                if (bus.RDY_start) begin
                    m_started = 1;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end else begin
                if (bus.RDY_next) begin
                    m_res[m_calls] = ~m_pat[m_calls];
                    m_calls++;
                    m_idle = 0;
                    if (m_calls == NCALLS) begin
                        m_active = 0;
                        m_done = 1;
                    end
                end else begin
                    m_idle++;
                end
            end
`ifdef EXAM_DRIVER_TIMEOUT_EN
            if (m_active && m_idle == TIMEOUT) begin
                m_active = 0; m_done = 1; m_err = 1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        logic exp_es, exp_en, exp_k;
        if (chk_en) begin
            exp_es = m_active && !m_started && bus.RDY_start && !rst;
            exp_en = m_active && m_started && bus.RDY_next && !rst;
            exp_k  = (m_active && m_started) ? m_pat[m_calls] : 1'b0;
            check("en_start", bus.EN_start, exp_es);
            check("en_next", bus.EN_next, exp_en);
            check("next_k", bus.next_k, exp_k);
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("error", error, m_err);
            check("result", result, m_res);
        end
    end

    // ---------------- drivers ----------------
    // mode 0: readies high; 1: start gap + toggling next ready; 2: go pulses
    // while busy; 3: next stall of 1000 cycles after 2 calls; 4: mid-run reset.
    task automatic set_ready(input int mode, input int rel);
        case (mode)
            1: begin
                bus.RDY_start = (rel >= 4);
                bus.RDY_next  = (rel >= 5) && (((rel - 5) % 2) == 0);
            end
            3: begin
                bus.RDY_start = 1'b1;
                bus.RDY_next  = !(rel >= 4 && rel < 1004);
            end
            default: begin
                bus.RDY_start = 1'b1;
                bus.RDY_next  = 1'b1;
            end
        endcase
    endtask

    task automatic do_run(input logic [NCALLS-1:0] pat, input int mode, input int budget,
                          output int lat, output int n_start, output logic [NCALLS-1:0] seq,
                          output int n_next);
        lat = -1; n_start = 0; seq = '0; n_next = 0;
        @(posedge clk); #1;
        go = 1'b1; pattern = pat; set_ready(mode, 0);
        @(posedge clk); #1;
        go = 1'b0;
        for (int rel = 1; rel <= budget; rel++) begin
            set_ready(mode, rel);
            if (mode == 2) begin
                go = (rel == 3) || (rel == 5);
                pattern = ~pat;
            end
            if (mode == 4) rst = (rel == 5);
            @(negedge clk);
            if (bus.EN_start === 1'b1) n_start++;
            if (bus.EN_next === 1'b1) begin
                if (n_next < NCALLS) seq[n_next] = bus.next_k;
                n_next++;
            end
            if (mode == 4 && rel == 5) check("rst_cycle_en_next", bus.EN_next, 1'b0);
            if (mode == 4 && rel == 6) begin
                check("after_rst_busy", busy, 1'b0);
                check("after_rst_done", done, 1'b0);
                check("after_rst_error", error, 1'b0);
                check("after_rst_result", result, 8'h00);
                check("after_rst_en_start", bus.EN_start, 1'b0);
                check("after_rst_en_next", bus.EN_next, 1'b0);
                check("after_rst_next_k", bus.next_k, 1'b0);
                check("after_rst_state", state_dbg, 3'd0);
                lat = rel;
                break;
            end
            if (done === 1'b1) begin
                lat = rel;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL run_wait: no done within %0d cycles in mode %0d", budget, mode);
        end
        go = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int                lat, n_start, n_next;
        logic [NCALLS-1:0] seq;

        rst = 1'b1; go = 1'b0; pattern = '0;
        bus.RDY_start = 1'b0; bus.RDY_next = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_result", result, 8'h00);
        check("reset_en_start", bus.EN_start, 1'b0);
        check("reset_en_next", bus.EN_next, 1'b0);
        check("reset_next_k", bus.next_k, 1'b0);
        check("reset_state", state_dbg, 3'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic run: A5 -> calls k=1,0,1,0,0,1,0,1, result 5A, done at t+10.
        do_run(8'hA5, 0, 50, lat, n_start, seq, n_next);
        check("basic_latency", lat, 10);
        check("basic_start_calls", n_start, 1);
        check("basic_next_calls", n_next, 8);
        check("basic_k_sequence", seq, 8'b1010_0101);
        check("basic_result", result, 8'h5A);

        // Ready gaps: done at t+1+3+16, same result.
        do_run(8'hA5, 1, 60, lat, n_start, seq, n_next);
        check("gap_latency", lat, 20);
        check("gap_start_calls", n_start, 1);
        check("gap_result", result, 8'h5A);

        // go while busy with a different pattern is ignored.
        do_run(8'h3C, 2, 50, lat, n_start, seq, n_next);
        check("busy_go_latency", lat, 10);
        check("busy_go_k_sequence", seq, 8'h3C);
        check("busy_go_result", result, 8'hC3);

        // Reset in the cycle of the 4th next call.
        do_run(8'h96, 4, 50, lat, n_start, seq, n_next);
        check("rst_next_calls", n_next, 3);

        // A fresh run after the reset completes normally.
        do_run(8'h0F, 0, 50, lat, n_start, seq, n_next);
        check("post_rst_latency", lat, 10);
        check("post_rst_result", result, 8'hF0);

        // Stall on RDY_next after 2 calls.
        do_run(8'hD2, 3, 1100, lat, n_start, seq, n_next);
`ifdef EXAM_DRIVER_TIMEOUT_EN
        check("timeout_latency", lat, 8);
        check("timeout_error", error, 1'b1);
        check("timeout_busy", busy, 1'b0);
        check("timeout_result", result, 8'h01);
`else
        check("stall_latency", lat, 1010);
        check("stall_error", error, 1'b0);
        check("stall_result", result, 8'h2D);
`endif

        // Relaunch from the ended state.
        do_run(8'h5A, 0, 50, lat, n_start, seq, n_next);
        check("relaunch_latency", lat, 10);
        check("relaunch_result", result, 8'hA5);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exam_driver.md
# exam_driver

Caller-side engine for the `start`/`next` method protocol of the exam assignment block. It plays the role the testbench normally plays by hand:
- one `start` action call;
- a programmed series of `next` actionvalue calls, each with a 1-bit argument `k`;
- capture of each returned bit into a result vector.

It sits between a host controller (or a bench) and the assignment DUT, and obeys the enable/ready method rules exactly.

## Interface
Parameters:
- `NCALLS`, 8: number of `next` calls per run; width of `pattern`/`result`.
- `TIMEOUT`, 255: maximum cycles spent waiting on a ready before aborting (≥1).

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `go`  in  1  launch a run; honoured only when not busy.
- `pattern`  in  NCALLS  `k` arguments; bit i is used on call i; latched on accepted `go`.
- `busy`  out  1  run in progress.
- `done`  out  1  last run ended; level, cleared by next accepted `go`.
- `error`  out  1  last run aborted by timeout (only with `EXAM_DRIVER_TIMEOUT_EN`).
- `result`  out  NCALLS  bit i = `next` value returned by call i.
- `EN_start`  out  1  start method enable.
- `RDY_start`  in  1  start method ready.
- `next_k`  out  1  argument of the next method.
- `EN_next`  out  1  next method enable.
- `next`  in  1  next method return value.
- `RDY_next`  in  1  next method ready.

## Operation
- States: IDLE, START, RUN, DONE, ERR.
- **IDLE/DONE/ERR, `go`=1**
  - latch `pattern`;
  - clear `result`, `done`, `error`, call index;
  - go to START.
- **START**
  - `EN_start = RDY_start`, driven combinationally the same cycle.
  - On a cycle with `EN_start`=1, go to RUN.
- **RUN**
  - `next_k = pattern_q[idx]`.
  - `EN_next = RDY_next`.
  - On a cycle with `EN_next`=1: `result[idx] <= next` (sampled that cycle), then idx++.
  - If idx was NCALLS-1, go to DONE instead.
- **DONE**: `done`=1. Remains until `go`.
- **Never assert an enable without its ready.** Enables are 0 in IDLE, DONE and ERR, and 0 in any cycle where `RST`=1.
- `next_k` is 0 outside RUN.
- `busy` = state is START or RUN.
- `go` while busy is ignored; `pattern` changes after latching have no effect.
- Index width: $clog2(NCALLS), min 1. It never exceeds NCALLS-1.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `result`=0, `EN_start`=0, `EN_next`=0, `next_k`=0. State is IDLE.
- Reset mid-run:
  - enables drop in the reset cycle itself;
  - the run is discarded;
  - the DUT is not notified.
- `go` registered at edge t gives START from cycle t+1.
- Best case, with readies always high:
  - `EN_start` in cycle t+1;
  - `EN_next` in cycles t+2 … t+NCALLS+1;
  - `done`=1 from cycle t+NCALLS+2.
- Ready low stalls the current state with no enable. There is no limit on stall length without the macro.
- `result` bits update at the edge ending the call cycle. `result` is stable whenever `done`=1.
- `go` in the same cycle that DONE is entered is ignored: the state is still RUN, so the driver is busy.

## Configuration
- `EXAM_DRIVER_TIMEOUT_EN` defined:
  - A wait counter, width $clog2(TIMEOUT+1), counts consecutive START/RUN cycles with no enable fired.
  - It resets to 0 when an enable fires and on entry to START.
  - Reaching TIMEOUT moves the state to ERR at the next edge, with `error`=1, `done`=1, `busy`=0.
  - `result` holds the partial results.
  - The exact TIMEOUT cycles of waiting are allowed; the abort happens at the edge after the TIMEOUT-th idle cycle.
- Undefined:
  - No counter, no ERR state.
  - `error` is tied to 0.
  - The driver waits indefinitely.

## Test plan
- Basic run:
  - Stimulus: NCALLS=8, readies held 1, `pattern`=8'hA5, DUT echoing `k` inverted.
  - Response:
    - `EN_start` for exactly 1 cycle;
    - 8 consecutive `EN_next` with `next_k` sequence 1,0,1,0,0,1,0,1;
    - `result`=8'h5A;
    - `done` at t+10.
- Ready gaps:
  - Stimulus: `RDY_start` low for 3 cycles; `RDY_next` toggling 1/0.
  - Response:
    - each enable is only ever asserted with its ready;
    - `done` at t+1+3+16;
    - `result` unchanged from the gap-free run.
- Busy `go`:
  - Stimulus: `go` pulsed at cycles t+3 and t+5 with a different `pattern`.
  - Response: ignored; `next_k` keeps following the first pattern.
- Reset mid-run:
  - Stimulus: `RST`=1 in the cycle of the 4th `EN_next`.
  - Response:
    - `EN_next`=0 in that cycle;
    - next cycle all outputs 0 and the state is IDLE;
    - a new `go` completes normally.
- Timeout (macro defined, TIMEOUT=4):
  - Stimulus: `RDY_next` held 0 after 2 calls.
  - Response:
    - `error`=1 and `done`=1 after 4 idle cycles;
    - `result[1:0]` valid, upper bits 0;
    - `busy`=0.
- Timeout path (macro undefined):
  - Stimulus: same stall, held 1000 cycles, then `RDY_next` released.
  - Response:
    - `error` stays 0;
    - the run completes with the correct `result`.
